popcnt_rr_sched: RTL and testbench

- Round-robin scheduler that shares one `mp_mult` bit-count datapath between N_REQ requesters.
- It arbitrates requests, loads the winner's operand, and sequences the datapath through clear, start and wait-for-ready.
- It returns the result tagged with the requester id, and aborts with an error flag if the datapath never reports ready.
- It sits between the board-level operand sources and the `mp_mult` instance.

---
 rtl/popcnt_rr_sched.sv | 101 ++++++++++
 tb/tb_popcnt_rr_sched.sv | 134 +++++++++++++
 2 files changed

// File: rtl/popcnt_rr_sched.sv
// popcnt_rr_sched: round-robin sharing of one popcount datapath across N_REQ requesters
module popcnt_rr_sched #(
    parameter int data_size = 8,
    parameter int N_REQ     = 4,
    parameter int TIMEOUT   = 32
) (
    input  logic                          clock,
    input  logic                          i_reset,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*data_size-1:0]    req_data,
    output logic [N_REQ-1:0]              gnt,
    output logic [data_size-1:0]          dp_data,
    output logic                          dp_clear,
    output logic                          dp_start,
    input  logic                          dp_ready,
    input  logic [data_size-1:0]          dp_result,
    output logic                          o_valid,
    output logic [$clog2(N_REQ)-1:0]      o_id,
    output logic [data_size-1:0]          o_result,
    output logic                          o_err,
    output logic                          o_busy
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, DONE} state_t;
    state_t state;
    logic [IW-1:0] ptr, gid, win;
    logic [TW-1:0] timer;
    logic [data_size-1:0] op_reg;
    assign dp_data = op_reg;
    // descending scan so the nearest requester after ptr is assigned last and wins
    always_comb begin
        win = ptr;
        for (int k = N_REQ; k >= 1; k--)
            if (req[IW'((int'(ptr) + k) % N_REQ)]) win = IW'((int'(ptr) + k) % N_REQ);
    end
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            gnt      <= '0;
            dp_clear <= 1'b0;
            dp_start <= 1'b0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_busy   <= 1'b0;
            o_id     <= '0;
            o_result <= '0;
            op_reg   <= '0;
            timer    <= '0;
            gid      <= '0;
            ptr      <= IW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state    <= CLEAR;
                    gnt      <= N_REQ'(1) << win;
                    dp_clear <= 1'b1;
                    o_busy   <= 1'b1;
                    op_reg   <= req_data[win*data_size +: data_size];
                    gid      <= win;
                end
                CLEAR: begin
                    state    <= START;
                    gnt      <= '0;
                    dp_clear <= 1'b0;
                    dp_start <= 1'b1;
                end
                START: begin
                    state    <= WAIT;
                    dp_start <= 1'b0;
                    timer    <= '0;
                end
                // ready is masked on the first WAIT cycle to skip a stale level
                WAIT: if (timer != '0 && dp_ready) begin
                    state    <= DONE;
                    o_result <= dp_result;
                    o_err    <= 1'b0;
                    o_valid  <= 1'b1;
                    o_id     <= gid;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state    <= DONE;
                    o_result <= '0;
                    o_err    <= 1'b1;
                    o_valid  <= 1'b1;
                    o_id     <= gid;
                    dp_clear <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    o_valid  <= 1'b0;
                    dp_clear <= 1'b0;
                    o_busy   <= 1'b0;
                    ptr      <= gid;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_popcnt_rr_sched.sv
// tb_popcnt_rr_sched: directed and random checks of the scheduler against a round-robin reference
module tb_popcnt_rr_sched;
    localparam int N  = 4;
    localparam int DS = 8;
    localparam int TO = 32;
    logic clock = 1'b0;
    logic i_reset;
    logic [N-1:0] req, gnt;
    logic [N*DS-1:0] req_data;
    logic [DS-1:0] dp_data, dp_result, o_result, acc;
    logic dp_clear, dp_start, dp_ready, o_valid, o_err, o_busy, rdy_q;
    logic [1:0] o_id;
    int total = 0, bad = 0, ptr_m, w, dp_mode, dp_dly, cnt;
    popcnt_rr_sched #(.data_size(DS), .N_REQ(N), .TIMEOUT(TO)) dut (
        .clock(clock), .i_reset(i_reset), .req(req), .req_data(req_data), .gnt(gnt),
        .dp_data(dp_data), .dp_clear(dp_clear), .dp_start(dp_start), .dp_ready(dp_ready),
        .dp_result(dp_result), .o_valid(o_valid), .o_id(o_id), .o_result(o_result),
        .o_err(o_err), .o_busy(o_busy));
    always #5 clock = ~clock;
    // datapath model: popcount latched at start, ready dp_dly cycles later (mode 1 tied high, mode 2 tied low)
    always @(posedge clock) begin
        if (dp_clear) begin
            rdy_q <= 1'b0;
            cnt   <= 0;
            acc   <= '0;
        end else if (dp_start) begin
            acc   <= 8'($countones(dp_data));
            cnt   <= dp_dly - 1;
            rdy_q <= (dp_dly == 1);
        end else if (cnt > 0) begin
            cnt   <= cnt - 1;
            rdy_q <= (cnt == 1);
        end
    end
    assign dp_ready  = dp_mode == 1 ? 1'b1 : dp_mode == 2 ? 1'b0 : rdy_q;
    assign dp_result = acc;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic txn(input logic [N-1:0] r, input logic [31:0] d, input int mode, input int dly, input bit chk_lat);
        int id, g, lat, el, eff;
        logic [DS-1:0] op;
        req = r;
        req_data = d;
        dp_mode = mode;
        dp_dly = dly;
        id = -1;
        for (int k = 1; k <= N; k++)
            if (id < 0 && r[(ptr_m + k) % N]) id = (ptr_m + k) % N;
        op = d[id*DS +: DS];
        g = 0;
        do begin @(negedge clock); g++; end while (gnt == 0 && g < 20);
        chk("gnt", gnt, 1 << id);
        if (chk_lat) chk("gnt_latency", g, 1);
        chk("clear_with_gnt", dp_clear, 1);
        chk("dp_data", dp_data, op);
        @(negedge clock);
        chk("start", dp_start, 1);
        chk("gnt_pulse", gnt, 0);
        lat = 1;
        do begin @(negedge clock); lat++; end while (!o_valid && lat < TO + 10);
        eff = mode == 1 ? 0 : dly;
        el = mode == 2 ? TO + 2 : (eff > 2 ? eff : 2) + 2;
        chk("o_valid", o_valid, 1);
        chk("latency", lat, el);
        chk("o_id", o_id, id);
        chk("o_err", o_err, mode == 2);
        chk("o_result", o_result, mode == 2 ? 0 : $countones(op));
        chk("abort_clear", dp_clear, mode == 2);
        chk("busy_done", o_busy, 1);
        ptr_m = id;
    endtask
    initial begin
        i_reset = 1'b0;
        req = '0;
        req_data = '0;
        dp_mode = 0;
        dp_dly = 4;
        ptr_m = N - 1;
        repeat (3) @(negedge clock);
        chk("rst_busy", o_busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_dp_data", dp_data, 0);
        i_reset = 1'b1;
        @(negedge clock);
        txn(4'b0001, 32'h000000B5, 0, 9, 1);
        for (int i = 0; i < 6; i++) txn(4'b1111, 32'hF0_3C_07_81, 0, 3 + i, 0);
        txn(4'b0101, 32'h00FF_00_01, 0, 5, 0);
        txn(4'b0101, 32'h00FF_00_01, 0, 5, 0);
        req = '0;
        repeat (2) @(negedge clock);
        txn(4'b0010, 32'h0000_7E00, 1, 1, 1);
        req = '0;
        repeat (2) @(negedge clock);
        txn(4'b0100, 32'h00AA_0000, 2, 1, 1);
        req = 4'b1000;
        req_data = 32'hC300_0000;
        dp_mode = 0;
        dp_dly = 12;
        w = 0;
        do begin @(negedge clock); w++; end while (gnt == 0 && w < 20);
        chk("mid_gnt", gnt, 4'b1000);
        req = '0;
        repeat (4) @(negedge clock);
        chk("mid_busy", o_busy, 1);
        #2 i_reset = 1'b0;
        #1;
        chk("async_busy", o_busy, 0);
        chk("async_err", o_err, 0);
        chk("async_id", o_id, 0);
        chk("async_result", o_result, 0);
        chk("async_dp_data", dp_data, 0);
        chk("async_ctl", {gnt, dp_clear, dp_start, o_valid}, 0);
        repeat (3) begin @(negedge clock); chk("rst_no_valid", o_valid, 0); end
        i_reset = 1'b1;
        ptr_m = N - 1;
        @(negedge clock);
        txn(4'b1001, 32'h1100_0003, 0, 4, 1);
        txn(4'b1000, 32'h1100_0003, 0, 4, 0);
        for (int i = 0; i < 20; i++) begin
            req = '0;
            repeat ($urandom_range(0, 2)) @(negedge clock);
            txn(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 5) == 0 ? 1 : 0, $urandom_range(1, 12), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
